mem_bus_arbiter: RTL and testbench

// Two-requester arbiter and sequencer for the multiplexed AddrData memory bus.

---
 rtl/mem_bus_arbiter_if.sv | 26 ++
 rtl/mem_bus_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Requester-side handshake and memController control signals for the
// two-requester AddrData bus arbiter. The tristate AddrData bus itself stays a plain inout port.
interface mem_bus_arbiter_if #(
    parameter int DATA_W = 16
);
    logic [1:0]             req;
    logic [1:0]             rwReq;
    logic [1:0][DATA_W-1:0] addrReq;
    logic [1:0][DATA_W-1:0] wdataReq;
    logic [1:0]             gnt;
    logic [1:0]             wack;
    logic [DATA_W-1:0]      rdata;
    logic [1:0]             rvalid;
    logic                   AddrValid;
    logic                   rwOut;

    modport master (
        input  req, rwReq, addrReq, wdataReq,
        output gnt, wack, rdata, rvalid, AddrValid, rwOut
    );

    modport slave (
        output req, rwReq, addrReq, wdataReq,
        input  gnt, wack, rdata, rvalid, AddrValid, rwOut
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter and sequencer for the multiplexed AddrData memory bus:
// one address cycle followed by BURST_LEN data beats, plus a turnaround after reads.
module mem_bus_arbiter #(
    parameter int BURST_LEN = 4,
    parameter int DATA_W    = 16
) (
    input  logic              clk,
    input  logic              resetH,
    mem_bus_arbiter_if.master bus,
    inout  wire  [DATA_W-1:0] AddrData
);
    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_TURN = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic               win_q, win_d;
    logic               last_q, last_d;
    logic               rw_q, rw_d;
    logic [DATA_W-1:0]  addr_q, addr_d;
    logic [CNT_W-1:0]   beat_q, beat_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [1:0]         rvalid_q, rvalid_d;

    logic               pick_s;
    logic [1:0]         gnt_s;
    logic [1:0]         wack_s;
    logic               avalid_s;
    logic               rwout_s;
    logic               drv_en_s;
    logic [DATA_W-1:0]  drv_val_s;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (resetH) begin
            state_q  <= ST_IDLE;
            win_q    <= 1'b0;
            last_q   <= 1'b1;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            beat_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            last_q   <= last_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            beat_q   <= beat_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Winner selection: a contested request goes to whoever was not served last
    always_comb begin
        pick_s = 1'b0;
        case (bus.req)
            2'b01:   pick_s = 1'b0;
            2'b10:   pick_s = 1'b1;
            2'b11:   pick_s = ~last_q;
            default: pick_s = 1'b0;
        endcase
    end

    // Next-state logic for the bus sequencer
    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        last_d   = last_q;
        rw_d     = rw_q;
        addr_d   = addr_q;
        beat_d   = beat_q;
        rdata_d  = rdata_q;
        rvalid_d = 2'b00;

        case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    win_d   = pick_s;
                    last_d  = pick_s;
                    rw_d    = bus.rwReq[pick_s];
                    addr_d  = bus.addrReq[pick_s];
                    state_d = ST_ADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                beat_d  = '0;
                state_d = ST_DATA;
            end
            ST_DATA: begin
                if (rw_q) begin
                    rdata_d  = AddrData;
                    rvalid_d = onehot2(win_q);
                end else begin
                    rdata_d  = rdata_q;
                end
                if (beat_q == LAST_BEAT) begin
                    beat_d  = '0;
                    state_d = rw_q ? ST_TURN : ST_IDLE;
                end else begin
                    beat_d  = beat_q + CNT_W'(1);
                    state_d = ST_DATA;
                end
            end
            ST_TURN: begin
                state_d = ST_IDLE;
            end
            default: begin
                beat_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bus-side outputs decoded from the registered state
    always_comb begin
        gnt_s     = 2'b00;
        wack_s    = 2'b00;
        avalid_s  = 1'b0;
        rwout_s   = 1'b0;
        drv_en_s  = 1'b0;
        drv_val_s = '0;

        case (state_q)
            ST_ADDR: begin
                gnt_s     = onehot2(win_q);
                avalid_s  = 1'b1;
                rwout_s   = rw_q;
                drv_en_s  = 1'b1;
                drv_val_s = addr_q;
            end
            ST_DATA: begin
                if (!rw_q) begin
                    wack_s    = onehot2(win_q);
                    drv_en_s  = 1'b1;
                    drv_val_s = bus.wdataReq[win_q];
                end else begin
                    drv_en_s  = 1'b0;
                end
            end
            default: begin
                drv_en_s = 1'b0;
            end
        endcase
    end

    assign AddrData      = drv_en_s ? drv_val_s : {DATA_W{1'bz}};
    assign bus.gnt       = gnt_s;
    assign bus.wack      = wack_s;
    assign bus.AddrValid = avalid_s;
    assign bus.rwOut     = rwout_s;
    assign bus.rdata     = rdata_q;
    assign bus.rvalid    = rvalid_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a small memController/memory model
// that captures write beats and drives read beats on the shared AddrData bus.
module tb_mem_bus_arbiter;
    localparam logic [15:0] PROBE = 16'h8001;

    logic        clk = 1'b0;
    logic        resetH;
    wire  [15:0] AddrData;
    logic        probe_en;

    int tests = 0;
    int fails = 0;

    logic [3:0][15:0] wd0, wd1;
    logic [1:0]       wb0, wb1;

    logic [15:0] mem [0:255];
    logic        m_active, m_rw;
    logic [15:0] m_addr;
    logic [1:0]  m_cnt;
    logic [7:0]  m_idx;

    logic [3:0][15:0] d10, d50;

    mem_bus_arbiter_if #(.DATA_W(16)) bus ();

    mem_bus_arbiter #(.BURST_LEN(4), .DATA_W(16)) dut (
        .clk      (clk),
        .resetH   (resetH),
        .bus      (bus),
        .AddrData (AddrData)
    );

    always #5 clk = ~clk;

    // Requesters present their current write beat and advance on wack
    assign bus.wdataReq = {wd1[wb1], wd0[wb0]};

    always_ff @(posedge clk) begin
        if (resetH) begin
            wb0 <= 2'd0;
            wb1 <= 2'd0;
        end else begin
            if (bus.gnt[0]) wb0 <= 2'd0;
            else if (bus.wack[0]) wb0 <= wb0 + 2'd1;
            if (bus.gnt[1]) wb1 <= 2'd0;
            else if (bus.wack[1]) wb1 <= wb1 + 2'd1;
        end
    end

    // memController model: latch address on AddrValid, then 4 beats
    assign m_idx = m_addr[7:0] + {6'd0, m_cnt};
    assign AddrData = (m_active && m_rw) ? mem[m_idx] : (probe_en ? PROBE : 16'hzzzz);

    always_ff @(posedge clk) begin
        if (resetH) begin
            m_active <= 1'b0;
            m_rw     <= 1'b0;
            m_addr   <= 16'h0000;
            m_cnt    <= 2'd0;
        end else if (bus.AddrValid) begin
            m_active <= 1'b1;
            m_rw     <= bus.rwOut;
            m_addr   <= AddrData;
            m_cnt    <= 2'd0;
        end else if (m_active) begin
            if (!m_rw) mem[m_idx] <= AddrData;
            m_cnt <= m_cnt + 2'd1;
            if (m_cnt == 2'd3) m_active <= 1'b0;
        end
    end

    function automatic logic [1:0] oh(input logic w);
        return w ? 2'b10 : 2'b01;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_gnt"},    {30'd0, bus.gnt},    32'd0);
        chk({tag, "_wack"},   {30'd0, bus.wack},   32'd0);
        chk({tag, "_rvalid"}, {30'd0, bus.rvalid}, 32'd0);
        chk({tag, "_rdata"},  {16'd0, bus.rdata},  32'd0);
        chk({tag, "_avalid"}, {31'd0, bus.AddrValid}, 32'd0);
        chk({tag, "_rwout"},  {31'd0, bus.rwOut},  32'd0);
        probe_en = 1'b1;
        #1;
        chk({tag, "_bus_released"}, {16'd0, AddrData}, {16'd0, PROBE});
        probe_en = 1'b0;
    endtask

    task automatic exp_addr(input logic w, input logic [15:0] a, input logic rw);
        step();
        chk("addr_gnt",    {30'd0, bus.gnt},       {30'd0, oh(w)});
        chk("addr_avalid", {31'd0, bus.AddrValid}, 32'd1);
        chk("addr_bus",    {16'd0, AddrData},      {16'd0, a});
        chk("addr_rwout",  {31'd0, bus.rwOut},     {31'd0, rw});
        chk("addr_wack",   {30'd0, bus.wack},      32'd0);
    endtask

    task automatic exp_wbeats(input logic w, input logic [3:0][15:0] d, input int nbeats, input int drop_at);
        for (int k = 0; k < nbeats; k++) begin
            step();
            chk($sformatf("wbeat%0d_wack", k),   {30'd0, bus.wack},      {30'd0, oh(w)});
            chk($sformatf("wbeat%0d_bus", k),    {16'd0, AddrData},      {16'd0, d[k]});
            chk($sformatf("wbeat%0d_gnt", k),    {30'd0, bus.gnt},       32'd0);
            chk($sformatf("wbeat%0d_avalid", k), {31'd0, bus.AddrValid}, 32'd0);
            if (k == drop_at) bus.req[w] = 1'b0;
        end
    endtask

    task automatic exp_rbeats(input logic w, input logic [3:0][15:0] d);
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("rbeat%0d_wack", k), {30'd0, bus.wack}, 32'd0);
            chk($sformatf("rbeat%0d_gnt", k),  {30'd0, bus.gnt},  32'd0);
            chk($sformatf("rbeat%0d_bus", k),  {16'd0, AddrData}, {16'd0, d[k]});
            if (k == 0) begin
                chk("rbeat0_rvalid", {30'd0, bus.rvalid}, 32'd0);
            end else begin
                chk($sformatf("rbeat%0d_rvalid", k), {30'd0, bus.rvalid}, {30'd0, oh(w)});
                chk($sformatf("rbeat%0d_rdata", k),  {16'd0, bus.rdata},  {16'd0, d[k-1]});
            end
        end
        step();
        probe_en = 1'b1;
        #1;
        chk("turn_bus_released", {16'd0, AddrData},      {16'd0, PROBE});
        chk("turn_rvalid",       {30'd0, bus.rvalid},    {30'd0, oh(w)});
        chk("turn_rdata",        {16'd0, bus.rdata},     {16'd0, d[3]});
        chk("turn_avalid",       {31'd0, bus.AddrValid}, 32'd0);
        chk("turn_gnt",          {30'd0, bus.gnt},       32'd0);
        probe_en = 1'b0;
    endtask

    task automatic exp_idle(input string tag);
        step();
        chk({tag, "_gnt"},    {30'd0, bus.gnt},       32'd0);
        chk({tag, "_wack"},   {30'd0, bus.wack},      32'd0);
        chk({tag, "_avalid"}, {31'd0, bus.AddrValid}, 32'd0);
        chk({tag, "_rvalid"}, {30'd0, bus.rvalid},    32'd0);
    endtask

    initial begin
        resetH       = 1'b1;
        probe_en     = 1'b0;
        bus.req      = 2'b00;
        bus.rwReq    = 2'b00;
        bus.addrReq  = '0;
        wd0          = '0;
        wd1          = '0;
        step();
        step();
        chk_reset_state("reset");

        // Test 1: requester 0 writes A..D at 0x0010
        resetH         = 1'b0;
        d10            = {16'h4D4D, 16'h3C3C, 16'h2B2B, 16'h1A1A};
        wd0            = d10;
        bus.addrReq[0] = 16'h0010;
        bus.req        = 2'b01;
        exp_addr(1'b0, 16'h0010, 1'b0);
        bus.req = 2'b00;
        exp_wbeats(1'b0, wd0, 4, -1);
        exp_idle("t1_idle");
        for (int k = 0; k < 4; k++)
            chk($sformatf("t1_mem%0d", k), {16'd0, mem[8'h10 + k[7:0]]}, {16'd0, d10[k]});

        // Test 2: requester 1 reads back 0x0010
        bus.rwReq[1]   = 1'b1;
        bus.addrReq[1] = 16'h0010;
        bus.req        = 2'b10;
        exp_addr(1'b1, 16'h0010, 1'b1);
        bus.req = 2'b00;
        exp_rbeats(1'b1, d10);
        exp_idle("t2_idle");

        // Test 3: simultaneous requests after reset, both held -> alternation
        resetH = 1'b1;
        step();
        resetH         = 1'b0;
        bus.rwReq      = 2'b00;
        bus.addrReq[0] = 16'h0020;
        bus.addrReq[1] = 16'h0030;
        wd0            = {16'h0A04, 16'h0A03, 16'h0A02, 16'h0A01};
        wd1            = {16'h0B04, 16'h0B03, 16'h0B02, 16'h0B01};
        bus.req        = 2'b11;
        exp_addr(1'b0, 16'h0020, 1'b0);
        exp_wbeats(1'b0, wd0, 4, -1);
        exp_idle("t3_idle_a");
        exp_addr(1'b1, 16'h0030, 1'b0);
        exp_wbeats(1'b1, wd1, 4, -1);
        exp_idle("t3_idle_b");
        exp_addr(1'b0, 16'h0020, 1'b0);
        bus.req = 2'b00;
        exp_wbeats(1'b0, wd0, 4, -1);
        exp_idle("t3_idle_c");

        // Test 4: reset during the second write beat, then a clean write
        wd0            = {16'h0C04, 16'h0C03, 16'h0C02, 16'h0C01};
        bus.addrReq[0] = 16'h0040;
        bus.req        = 2'b01;
        exp_addr(1'b0, 16'h0040, 1'b0);
        bus.req = 2'b00;
        exp_wbeats(1'b0, wd0, 2, -1);
        resetH = 1'b1;
        step();
        chk_reset_state("t4_abort");
        resetH         = 1'b0;
        d50            = {16'h5004, 16'h5003, 16'h5002, 16'h5001};
        wd0            = d50;
        bus.addrReq[0] = 16'h0050;
        bus.req        = 2'b01;
        exp_addr(1'b0, 16'h0050, 1'b0);
        bus.req = 2'b00;
        exp_wbeats(1'b0, wd0, 4, -1);
        exp_idle("t4_idle");
        for (int k = 0; k < 4; k++)
            chk($sformatf("t4_mem%0d", k), {16'd0, mem[8'h50 + k[7:0]]}, {16'd0, d50[k]});

        // Test 5: req0 drops in beat 1, burst still completes with no new grant
        wd0            = {16'h6004, 16'h6003, 16'h6002, 16'h6001};
        bus.addrReq[0] = 16'h0060;
        bus.req        = 2'b01;
        exp_addr(1'b0, 16'h0060, 1'b0);
        exp_wbeats(1'b0, wd0, 4, 1);
        exp_idle("t5_idle_a");
        exp_idle("t5_idle_b");
        chk("t5_mem3", {16'd0, mem[8'h63]}, 32'h0000_6004);

        // Test 6: read with a write pending behind it -> exactly one TURN cycle
        bus.rwReq[1]   = 1'b1;
        bus.addrReq[1] = 16'h0050;
        bus.req        = 2'b10;
        exp_addr(1'b1, 16'h0050, 1'b1);
        wd0            = {16'h7004, 16'h7003, 16'h7002, 16'h7001};
        bus.rwReq[0]   = 1'b0;
        bus.addrReq[0] = 16'h0070;
        bus.req        = 2'b01;
        exp_rbeats(1'b1, d50);
        exp_idle("t6_idle");
        exp_addr(1'b0, 16'h0070, 1'b0);
        bus.req = 2'b00;
        exp_wbeats(1'b0, wd0, 4, -1);
        exp_idle("t6_idle_end");
        chk("t6_mem0", {16'd0, mem[8'h70]}, 32'h0000_7001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
